param_shift_reg: RTL and testbench
==================================

Name: param_shift_reg

Overview:
- Parametrised universal shift register; next generation of the team's fixed 4-bit parallel-load / serial-shift register.
- Adds:
  - configurable width
  - selectable shift direction
  - shift enable
  - parallel readback
  - a shift counter with an "empty" flag, so a parallel word can be serialised without external counting.
- Sits between a parallel data source and a serial link (PISO), or the reverse (SIPO via q).

Parameters:
- WIDTH, 4, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- ld  input  1  parallel load strobe.
- en  input  1  shift enable.
- dir  input  1  shift direction: 0 = right (toward LSB), 1 = left (toward MSB).
- d_in  input  1  serial input bit.
- pd_in  input  WIDTH  parallel load data.
- out  output  1  serial output bit (combinational from register).
- q  output  WIDTH  register contents.
- cnt  output  CNT_W  shifts performed since last load, saturating at WIDTH.
- empty  output  1  high when cnt == WIDTH.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - q = 0
  - cnt = WIDTH
  - empty = 1
  - Reset asserted mid-shift aborts immediately; the first edge after release obeys normal priority.
- Priority per rising edge: reset > ld > en > hold.
- ld=1: q <= pd_in, cnt <= 0. en and dir are ignored that cycle.
- ld=0, en=1, dir=0 (right shift):
  - q <= {d_in, q[WIDTH-1:1]}
  - cnt <= (cnt==WIDTH) ? WIDTH : cnt+1
- ld=0, en=1, dir=1 (left shift):
  - q <= {q[WIDTH-2:0], d_in}
  - cnt as above.
- ld=0, en=0: q and cnt hold.
- out:
  - q[0] when dir=0; q[WIDTH-1] when dir=1.
  - Combinational from q and dir, so out shows the bit leaving on the next enabled edge. Latency 0 from q.
- empty: combinational, (cnt == WIDTH). Asserts in the cycle after the WIDTH-th shift following a load.
- Shifting while empty=1 still shifts data; cnt stays saturated at WIDTH, with no wrap to 0.
- Changing dir between shifts is legal. cnt keeps counting; no flush is performed.
- ld asserted on the edge where cnt would reach WIDTH: load wins, cnt = 0, empty stays 0.
- No X propagation from ld/en/dir while reset=0.

Optional Feature:
- Macro: PARAM_SHIFT_REG_ROTATE_EN.
- When defined:
  - Adds input port rot (1 bit).
  - When rot=1 during a shift, the bit shifted out re-enters at the opposite end in place of d_in:
    - right: q <= {q[0], q[WIDTH-1:1]}
    - left: q <= {q[WIDTH-2:0], q[WIDTH-1]}
  - cnt and empty behave identically to a normal shift.
  - rot=0 gives normal behaviour.
- When undefined: no rot port; d_in is always the fill bit.

Test Plan:
- (1) WIDTH=4. Hold reset=0 for 10 ns, then release -> q=0000, cnt=4, empty=1, out=0. Assert reset again mid-shift -> q=0000 immediately, without waiting for a clock edge.
- (2) ld=1, pd_in=0101, one edge -> q=0101, cnt=0, empty=0, out=1 (dir=0). Then en=1, dir=0, d_in=1 for 4 edges -> out sequence 1,0,1,0; q ends 1111; cnt=4; empty=1 after edge 4.
- (3) ld=1, pd_in=1000; then en=1, dir=1, d_in=0 -> out sequence 1,0,0,0; q ends 0000; empty=1. A 5th shift leaves cnt=4.
- (4) ld=1 and en=1 on the same edge with pd_in=0011 -> q=0011, cnt=0; no shift occurs.
- (5) en=0 for 3 edges after a load of 1010 -> q stays 1010, cnt stays 0. ld at cnt=3 -> cnt=0, empty never asserts.
- (6) With PARAM_SHIFT_REG_ROTATE_EN: load 1001, rot=1, dir=0, 4 shifts -> q sequence 1100, 0110, 0011, 1001; empty=1 at end.

Source files
------------

// File: rtl/param_shift_reg.sv
// param_shift_reg: parametrised universal shift register.
// Provides parallel load, left/right serial shift with enable, parallel
// readback, and a saturating shift counter with an "empty" flag so that a
// loaded word can be serialised without external counting.
// Optional build macro: PARAM_SHIFT_REG_ROTATE_EN adds a 'rot' input. When
// rot is high, the bit leaving the register re-enters at the opposite end
// instead of d_in.
module param_shift_reg #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             en,
  input  logic             dir,
  input  logic             d_in,
`ifdef PARAM_SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] pd_in,
  output logic             out,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] cnt,
  output logic             empty
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] q_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             fill_s;

  // Select the bit entering the vacated end: serial input, or the outgoing bit when rotating.
  always_comb begin
    fill_s = d_in;
`ifdef PARAM_SHIFT_REG_ROTATE_EN
    if (rot) begin
      fill_s = dir ? q_r[WIDTH-1] : q_r[0];
    end else begin
      fill_s = d_in;
    end
`endif
  end

  // Next-state selection with priority load > shift > hold; counter saturates at WIDTH.
  always_comb begin
    q_next_s   = q_r;
    cnt_next_s = cnt_r;
    if (ld) begin
      q_next_s   = pd_in;
      cnt_next_s = '0;
    end else if (en) begin
      case (dir)
        1'b0:    q_next_s = {fill_s, q_r[WIDTH-1:1]};
        1'b1:    q_next_s = {q_r[WIDTH-2:0], fill_s};
        default: q_next_s = q_r;
      endcase
      if (cnt_r == CNT_FULL) begin
        cnt_next_s = CNT_FULL;
      end else begin
        cnt_next_s = cnt_r + CNT_ONE;
      end
    end else begin
      q_next_s   = q_r;
      cnt_next_s = cnt_r;
    end
  end

  // State registers; reset clears data and marks the register as fully drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r   <= '0;
      cnt_r <= CNT_FULL;
    end else begin
      q_r   <= q_next_s;
      cnt_r <= cnt_next_s;
    end
  end

  // The serial output is the bit that would leave on the next enabled edge.
  always_comb begin
    case (dir)
      1'b0:    out = q_r[0];
      1'b1:    out = q_r[WIDTH-1];
      default: out = q_r[0];
    endcase
  end

  assign q     = q_r;
  assign cnt   = cnt_r;
  assign empty = (cnt_r == CNT_FULL);

endmodule

// File: tb/tb_param_shift_reg.sv
// Table-driven bench for param_shift_reg at WIDTH=4, plus hand-written
// sequences for asynchronous reset behaviour.
module tb_param_shift_reg;

  logic       clk;
  logic       reset;
  logic       ld;
  logic       en;
  logic       dir;
  logic       d_in;
  logic       rot;
  logic [3:0] pd_in;
  logic       out;
  logic [3:0] q;
  logic [2:0] cnt;
  logic       empty;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       ld;
    logic       en;
    logic       dir;
    logic       d_in;
    logic       rot;
    logic [3:0] pd;
    logic [3:0] exp_q;
    logic [2:0] exp_cnt;
    logic       exp_empty;
    logic       exp_out;
  } vec_t;

  vec_t vecs[$];

  param_shift_reg #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ld    (ld),
    .en    (en),
    .dir   (dir),
    .d_in  (d_in),
`ifdef PARAM_SHIFT_REG_ROTATE_EN
    .rot   (rot),
`endif
    .pd_in (pd_in),
    .out   (out),
    .q     (q),
    .cnt   (cnt),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic l, input logic e, input logic dr, input logic di,
                     input logic r, input logic [3:0] pd, input logic [3:0] eq,
                     input logic [2:0] ec, input logic ee, input logic eo);
    vec_t v;
    v.ld = l; v.en = e; v.dir = dr; v.d_in = di; v.rot = r; v.pd = pd;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_empty = ee; v.exp_out = eo;
    vecs.push_back(v);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //   ld    en    dir   d_in  rot   pd       q        cnt     empty out
    // Load 0101, shift right with d_in=1 four times.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b0101, 3'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1010, 3'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1101, 3'd2, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1110, 3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111, 3'd4, 1'b1, 1'b1);
    // Load 1000, shift left with d_in=0; fifth shift keeps cnt saturated.
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 4'b1000, 3'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd3, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd4, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd4, 1'b1, 1'b0);
    // Load and enable together: load wins, no shift.
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0011, 3'd0, 1'b0, 1'b1);
    // Load 1010 then hold three edges.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1010, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 4'b1010, 3'd0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010, 3'd0, 1'b0, 1'b0);
    // Three shifts, then load on the edge where cnt would have reached 4.
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0101, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0010, 3'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0001, 3'd3, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010, 3'd0, 1'b0, 1'b0);
    // Direction change between shifts keeps counting.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 3'd0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b1011, 3'd1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0110, 3'd2, 1'b0, 1'b0);
`ifdef PARAM_SHIFT_REG_ROTATE_EN
    // Rotate right four times returns the original word.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 4'b1001, 3'd0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100, 3'd1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0110, 3'd2, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0011, 3'd3, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1001, 3'd4, 1'b1, 1'b1);
    // Rotate left with d_in=0 brings the MSB round to the LSB.
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0011, 3'd4, 1'b1, 1'b0);
`endif

    // Reset from time zero, released away from a clock edge.
    reset = 1'b0; ld = 1'b0; en = 1'b0; dir = 1'b0; d_in = 1'b0; rot = 1'b0;
    pd_in = 4'b0000;
    #10;
    reset = 1'b1;
    #1;
    check("reset_q", 32'(q), 32'h0);
    check("reset_cnt", 32'(cnt), 32'd4);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_out", 32'(out), 32'd0);

    // Apply the vector table.
    foreach (vecs[i]) begin
      ld = vecs[i].ld; en = vecs[i].en; dir = vecs[i].dir;
      d_in = vecs[i].d_in; rot = vecs[i].rot; pd_in = vecs[i].pd;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("v%0d_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("v%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
    end

    // Asynchronous reset in the middle of a shift sequence.
    ld = 1'b1; en = 1'b0; dir = 1'b0; d_in = 1'b1; rot = 1'b0; pd_in = 4'b1111;
    @(posedge clk);
    #1;
    ld = 1'b0; en = 1'b1;
    @(posedge clk);
    #1;
    check("midshift_q", 32'(q), 32'hF);
    check("midshift_cnt", 32'(cnt), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_q", 32'(q), 32'h0);
    check("async_rst_cnt", 32'(cnt), 32'd4);
    check("async_rst_empty", 32'(empty), 32'd1);
    // Edges while held in reset must not disturb state.
    @(posedge clk);
    #1;
    check("held_rst_q", 32'(q), 32'h0);
    // First edge after release obeys load priority over shift.
    ld = 1'b1; en = 1'b1; pd_in = 4'b0011;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_q", 32'(q), 32'h3);
    check("post_rst_cnt", 32'(cnt), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
